wb_gpio: RTL and testbench
==========================

WB_GPIO -- requirements
Module: wb_gpio

Interface
REQ-001 Parameter N, default 4: GPIO pin count, legal range 1..32.
REQ-002 Parameter DEBOUNCE, default 16: stable cycles needed before an input change is accepted; 0 bypasses the debouncer.
REQ-003 Parameter RESET_OUT, default '0: reset value of the output register, N bits.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 wb  wb_if slave  -  pipelined Wishbone B4 slave port; uses adr[4:2], dat_m, sel, we, stb, cyc; drives dat_s, ack, stall, err.
REQ-007 gpio_i  input  N  asynchronous input pins, e.g. buttons or switches.
REQ-008 gpio_o  output  N  registered output pins, e.g. LEDs.
REQ-009 irq  output  1  level interrupt, registered.

Function
REQ-010 Register map, word offsets: 0x00 OUT rw; 0x04 SET wo; 0x08 CLR wo; 0x0C TGL wo; 0x10 IN ro; 0x14 IEN rw; 0x18 IPEND rw1c; 0x1C IPOL rw (0 = rising edge, 1 = falling edge).
REQ-011 A request is accepted when cyc&stb; stall is tied 0; ack is asserted exactly one cycle after acceptance, with dat_s valid in that cycle.
REQ-012 Back-to-back requests produce one ack per cycle.
REQ-013 err is tied 0.
REQ-014 Unmapped, write-only and reserved-bit reads return 0; writes to them have no effect.
REQ-015 Bits [31:N] read 0.
REQ-016 Writes honour sel byte lanes; a bit is written only if its byte lane is selected.
REQ-017 SET, CLR and TGL writes update OUT as OUT|d, OUT&~d and OUT^d respectively, one cycle after acceptance.
REQ-018 gpio_o equals OUT.
REQ-019 Each gpio_i bit passes a 2-flop synchroniser, then the debouncer.
REQ-020 Debouncer, per pin: a counter resets whenever the synchronised value equals the stable value; otherwise it increments. When it reaches DEBOUNCE, the stable value is updated and the counter cleared.
REQ-021 Counter width is clog2(DEBOUNCE+1).
REQ-022 Input latency: a level held at gpio_i from cycle t appears in IN at cycle t+2+DEBOUNCE. With DEBOUNCE=0 it appears at t+2.
REQ-023 A glitch shorter than DEBOUNCE cycles never changes IN.
REQ-024 Edge detection runs on the debounced value, using IPOL per pin. A detected edge sets the IPEND bit in the same cycle IN changes.
REQ-025 An IPEND bit sets regardless of IEN; IEN only gates irq.
REQ-026 Writing 1 to an IPEND bit clears it; writing 0 leaves it unchanged.
REQ-027 If a clear and a new edge hit the same bit in the same cycle, the set wins.
REQ-028 irq = |(IPEND & IEN), registered, so it lags IPEND by one cycle.
REQ-029 Changing IPOL takes effect on the next edge and never generates an edge by itself.

Reset
REQ-030 While rst is high at a clk edge: OUT=RESET_OUT; IEN, IPEND, IPOL = 0; ack=0; irq=0; synchronisers, stable values and counters = 0.
REQ-031 A request in flight when rst asserts is dropped with no ack.
REQ-032 No edge is flagged on the first cycle after reset, even if an input is already high.

Structure
REQ-033 Package wb_gpio_pkg holds the register offset localparams and the register-index enum.
REQ-034 One sub-module, gpio_debounce, covers a single pin (synchroniser, counter, stable value) and is instantiated N times via a generate loop.

Verification
REQ-035 Parameters N=4, DEBOUNCE=4. Write OUT=0x5, then SET 0x2, CLR 0x1, TGL 0xC -> gpio_o = 0x5, 0x7, 0x6, 0xA, each one cycle after its ack.
REQ-036 Raise gpio_i[0] at cycle t and hold it -> IN=0x1 at t+6. A 3-cycle pulse on gpio_i[1] -> IN bit 1 stays 0.
REQ-037 IEN=0x1, IPOL=0, rising edge on pin 0 -> IPEND=0x1, and irq rises one cycle later. Write IPEND=0x1 -> irq falls.
REQ-038 IPOL=0x2, falling edge on pin 1 coinciding with a W1C write of 0x2 -> IPEND bit 1 stays 1.
REQ-039 Back-to-back reads of 0x00, 0x10, 0x1C, 0x20 -> four consecutive acks; 0x20 returns 0; err never 1.
REQ-040 Assert rst during a pending access with OUT=0xF and RESET_OUT=0x3 -> no ack, gpio_o=0x3, irq=0.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO block: register offsets, register
// index enum and the byte-lane expansion helper.
package wb_gpio_pkg;

    localparam logic [4:0] ADR_OUT   = 5'h00;
    localparam logic [4:0] ADR_SET   = 5'h04;
    localparam logic [4:0] ADR_CLR   = 5'h08;
    localparam logic [4:0] ADR_TGL   = 5'h0C;
    localparam logic [4:0] ADR_IN    = 5'h10;
    localparam logic [4:0] ADR_IEN   = 5'h14;
    localparam logic [4:0] ADR_IPEND = 5'h18;
    localparam logic [4:0] ADR_IPOL  = 5'h1C;

    typedef enum logic [2:0] {
        REG_OUT   = 3'd0,
        REG_SET   = 3'd1,
        REG_CLR   = 3'd2,
        REG_TGL   = 3'd3,
        REG_IN    = 3'd4,
        REG_IEN   = 3'd5,
        REG_IPEND = 3'd6,
        REG_IPOL  = 3'd7
    } reg_idx_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input pin: two-flop synchroniser followed by a stability counter.
// 'change' is high in the cycle before 'stable' flips, so edge logic can act on the same edge.
module gpio_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stable,
    output logic change
);

    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pin;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign stable = sync2_reg;
            assign change = sync1_reg ^ sync2_reg;
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

            logic [CW-1:0] cnt_reg;
            logic          stable_reg;

            // The DEBOUNCE-th consecutive mismatch commits the new value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync2_reg == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == LAST) begin
                    stable_reg <= sync2_reg;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign stable = stable_reg;
            assign change = (sync2_reg != stable_reg) && (cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_gpio.sv
// Pipelined Wishbone GPIO block: output register with set/clear/toggle aliases,
// debounced inputs, per-pin edge interrupts with selectable polarity.
module wb_gpio
    import wb_gpio_pkg::*;
#(
    parameter int           N         = 4,
    parameter int           DEBOUNCE  = 16,
    parameter logic [N-1:0] RESET_OUT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:2]   wb_adr,
    input  logic [31:0]   wb_dat_m,
    input  logic [3:0]    wb_sel,
    input  logic          wb_we,
    input  logic          wb_stb,
    input  logic          wb_cyc,
    output logic [31:0]   wb_dat_s,
    output logic          wb_ack,
    output logic          wb_stall,
    output logic          wb_err,
    input  logic [N-1:0]  gpio_i,
    output logic [N-1:0]  gpio_o,
    output logic          irq
);

    logic [N-1:0] in_bits;
    logic [N-1:0] change;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pin
            gpio_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .pin    (gpio_i[gi]),
                .stable (in_bits[gi]),
                .change (change[gi])
            );
        end
    endgenerate

    logic [N-1:0] out_reg, out_next;
    logic [N-1:0] ien_reg, ien_next;
    logic [N-1:0] ipend_reg, ipend_next;
    logic [N-1:0] ipol_reg, ipol_next;
    logic         ack_reg;
    logic         irq_reg;
    logic [31:0]  dat_s_reg;

    logic         accept;
    logic         mapped;
    reg_idx_t     idx;
    logic [31:0]  lane_m;
    logic [31:0]  wr_bits;
    logic [N-1:0] mask_n;
    logic [N-1:0] wr_n;
    logic [N-1:0] ipend_clr;
    logic [N-1:0] edge_hit;
    logic [N-1:0] rd_n;
    logic [31:0]  rd_data;
    logic         unused_hi;

    assign accept  = wb_cyc & wb_stb;
    assign mapped  = (wb_adr[31:5] == '0);
    assign lane_m  = lane_mask(wb_sel);
    assign wr_bits = wb_dat_m & lane_m;
    assign mask_n  = lane_m[N-1:0];
    assign wr_n    = wr_bits[N-1:0];
    assign unused_hi = ^{wr_bits, lane_m};

    // 'change' means the stable value is about to invert, so the current stable value
    // tells the direction: a rising edge is a change while stable is 0.
    assign edge_hit = change & ~(in_bits ^ ipol_reg);

    always_comb begin
        idx = REG_OUT;
        case ({wb_adr[4:2], 2'b00})
            ADR_OUT:   idx = REG_OUT;
            ADR_SET:   idx = REG_SET;
            ADR_CLR:   idx = REG_CLR;
            ADR_TGL:   idx = REG_TGL;
            ADR_IN:    idx = REG_IN;
            ADR_IEN:   idx = REG_IEN;
            ADR_IPEND: idx = REG_IPEND;
            ADR_IPOL:  idx = REG_IPOL;
            default:   idx = REG_OUT;
        endcase
    end

    always_comb begin
        out_next  = out_reg;
        ien_next  = ien_reg;
        ipol_next = ipol_reg;
        ipend_clr = '0;
        if (accept && wb_we && mapped) begin
            case (idx)
                REG_OUT:   out_next  = (out_reg & ~mask_n) | wr_n;
                REG_SET:   out_next  = out_reg | wr_n;
                REG_CLR:   out_next  = out_reg & ~wr_n;
                REG_TGL:   out_next  = out_reg ^ wr_n;
                REG_IEN:   ien_next  = (ien_reg & ~mask_n) | wr_n;
                REG_IPEND: ipend_clr = wr_n;
                REG_IPOL:  ipol_next = (ipol_reg & ~mask_n) | wr_n;
                default:   ;
            endcase
        end
        // A fresh edge beats a simultaneous write-one-to-clear.
        ipend_next = (ipend_reg & ~ipend_clr) | edge_hit;
    end

    always_comb begin
        rd_n = '0;
        if (mapped) begin
            case (idx)
                REG_OUT:   rd_n = out_reg;
                REG_IN:    rd_n = in_bits;
                REG_IEN:   rd_n = ien_reg;
                REG_IPEND: rd_n = ipend_reg;
                REG_IPOL:  rd_n = ipol_reg;
                default:   rd_n = '0;
            endcase
        end
        rd_data = '0;
        rd_data[N-1:0] = rd_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= RESET_OUT;
            ien_reg   <= '0;
            ipend_reg <= '0;
            ipol_reg  <= '0;
            ack_reg   <= 1'b0;
            irq_reg   <= 1'b0;
            dat_s_reg <= '0;
        end else begin
            out_reg   <= out_next;
            ien_reg   <= ien_next;
            ipend_reg <= ipend_next;
            ipol_reg  <= ipol_next;
            ack_reg   <= accept;
            irq_reg   <= |(ipend_reg & ien_reg);
            dat_s_reg <= (accept && !wb_we) ? rd_data : '0;
        end
    end

    assign wb_dat_s = dat_s_reg;
    assign wb_ack   = ack_reg;
    assign wb_stall = 1'b0;
    assign wb_err   = 1'b0;
    assign gpio_o   = out_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_wb_gpio.sv
// Directed bench for wb_gpio: bus stimulus pushes expected responses into a
// scoreboard queue that a negedge monitor pops on every ack.
module tb_wb_gpio;

    localparam int           N         = 4;
    localparam int           DEBOUNCE  = 4;
    localparam logic [N-1:0] RESET_OUT = 4'h3;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:2]   wb_adr;
    logic [31:0]   wb_dat_m;
    logic [3:0]    wb_sel;
    logic          wb_we;
    logic          wb_stb;
    logic          wb_cyc;
    logic [31:0]   wb_dat_s;
    logic          wb_ack;
    logic          wb_stall;
    logic          wb_err;
    logic [N-1:0]  gpio_i;
    logic [N-1:0]  gpio_o;
    logic          irq;

    always #5 clk = ~clk;

    wb_gpio #(.N(N), .DEBOUNCE(DEBOUNCE), .RESET_OUT(RESET_OUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr   (wb_adr),
        .wb_dat_m (wb_dat_m),
        .wb_sel   (wb_sel),
        .wb_we    (wb_we),
        .wb_stb   (wb_stb),
        .wb_cyc   (wb_cyc),
        .wb_dat_s (wb_dat_s),
        .wb_ack   (wb_ack),
        .wb_stall (wb_stall),
        .wb_err   (wb_err),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .irq      (irq)
    );

    typedef struct {
        logic [31:0] data;
        bit          chk;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry.
    always @(negedge clk) begin
        if (wb_ack === 1'b1) begin : mon
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 with no request outstanding, expected no ack");
            end else begin
                e = sb.pop_front();
                check({e.name, "_err"}, 32'(wb_err), 32'd0);
                if (e.chk) check(e.name, wb_dat_s, e.data);
            end
        end
    end

    task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit chk, input logic [31:0] exp,
                       input string name, input bit push = 1'b1);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_adr   = adr[31:2];
        wb_dat_m = dat;
        wb_sel   = sel;
        if (push) sb.push_back('{data: exp, chk: chk, name: name});
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        bus(1'b1, adr, dat, sel, 1'b0, 32'd0, "wr");
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'd0, 4'hF, 1'b1, exp, name);
    endtask

    task automatic idle();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        gpio_i   = '0;
        wb_adr   = '0;
        wb_dat_m = '0;
        wb_sel   = '0;
        idle();
        cycles(3);
        rst = 1'b0;

        // Reset state
        check("reset_gpio_o", 32'(gpio_o), 32'h3);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_ack", 32'(wb_ack), 32'd0);
        rd(32'h00, 32'h3, "reset_out");
        rd(32'h14, 32'h0, "reset_ien");
        rd(32'h18, 32'h0, "reset_ipend");
        rd(32'h1C, 32'h0, "reset_ipol");
        idle();

        // Output register and its set/clear/toggle aliases
        wr(32'h00, 32'h5); idle(); cycles(1); check("out_write", 32'(gpio_o), 32'h5);
        wr(32'h04, 32'h2); idle(); cycles(1); check("out_set",   32'(gpio_o), 32'h7);
        wr(32'h08, 32'h1); idle(); cycles(1); check("out_clr",   32'(gpio_o), 32'h6);
        wr(32'h0C, 32'hC); idle(); cycles(1); check("out_tgl",   32'(gpio_o), 32'hA);
        wr(32'h00, 32'hF, 4'h2); idle(); cycles(1); check("out_lane_unsel", 32'(gpio_o), 32'hA);
        rd(32'h00, 32'hA, "out_readback");
        rd(32'h04, 32'h0, "set_reads_zero");
        idle();

        // Rising edge on pin 0 with IEN=1, IPOL=0
        wr(32'h14, 32'h1);
        wr(32'h1C, 32'h0);
        idle();
        cycles(2);
        gpio_i[0] = 1'b1;
        cycles(5);
        rd(32'h10, 32'h0, "in_before_t6");
        check("irq_not_yet", 32'(irq), 32'd0);
        rd(32'h10, 32'h1, "in_at_t6");
        check("irq_lags_ipend", 32'(irq), 32'd1);
        rd(32'h18, 32'h1, "ipend_rise");
        wr(32'h18, 32'h1);
        idle();
        cycles(2);
        check("irq_after_w1c", 32'(irq), 32'd0);
        rd(32'h18, 32'h0, "ipend_after_w1c");
        idle();

        // Three-cycle glitch on pin 1 must be filtered
        gpio_i[1] = 1'b1;
        cycles(3);
        gpio_i[1] = 1'b0;
        cycles(8);
        rd(32'h10, 32'h1, "in_glitch_filtered");
        rd(32'h18, 32'h0, "ipend_glitch");
        idle();

        // Falling-edge polarity on pin 1; edge coincides with a W1C of the same bit
        wr(32'h1C, 32'h2);
        idle();
        gpio_i[1] = 1'b1;
        cycles(10);
        rd(32'h18, 32'h0, "ipend_rise_ignored");
        rd(32'h10, 32'h3, "in_pin1_high");
        idle();
        gpio_i[1] = 1'b0;
        cycles(5);
        wr(32'h18, 32'h2);
        idle();
        cycles(1);
        rd(32'h18, 32'h2, "ipend_set_wins");
        check("irq_masked", 32'(irq), 32'd0);
        wr(32'h18, 32'h2);
        rd(32'h18, 32'h0, "ipend_bit1_cleared");
        idle();

        // Back-to-back reads, including an unmapped offset
        rd(32'h00, 32'hA, "b2b_out");
        check("b2b_ack0", 32'(wb_ack), 32'd1);
        rd(32'h10, 32'h1, "b2b_in");
        check("b2b_ack1", 32'(wb_ack), 32'd1);
        rd(32'h1C, 32'h2, "b2b_ipol");
        check("b2b_ack2", 32'(wb_ack), 32'd1);
        rd(32'h20, 32'h0, "b2b_unmapped");
        check("b2b_ack3", 32'(wb_ack), 32'd1);
        idle();
        cycles(1);

        // Reset during a pending access, with OUT=0xF and irq high
        wr(32'h00, 32'hF); idle(); cycles(1); check("out_all_ones", 32'(gpio_o), 32'hF);
        wr(32'h1C, 32'h3);
        idle();
        gpio_i[0] = 1'b0;
        cycles(8);
        check("irq_before_rst", 32'(irq), 32'd1);
        rst = 1'b1;
        bus(1'b1, 32'h00, 32'h0, 4'hF, 1'b0, 32'd0, "dropped", 1'b0);
        check("rst_no_ack", 32'(wb_ack), 32'd0);
        check("rst_gpio_o", 32'(gpio_o), 32'h3);
        check("rst_irq", 32'(irq), 32'd0);
        idle();
        cycles(1);
        rst = 1'b0;
        cycles(2);
        check("post_rst_no_ack", 32'(wb_ack), 32'd0);
        rd(32'h18, 32'h0, "post_rst_ipend");
        rd(32'h14, 32'h0, "post_rst_ien");
        rd(32'h00, 32'h3, "post_rst_out");
        idle();
        cycles(3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
